phase_measure_dprintf_summary: RTL

//  Consumes clocking_phase_measure responses in the cpm clock domain and

---
 rtl/phase_measure_dprintf_summary.sv | 108 ++++++++++
 1 files changed

// File: rtl/phase_measure_dprintf_summary.sv
// Accumulates 2**LOG2_SAMPLES phase measurements and emits one dprintf summary
// request (min/max/mean delay, abort/dropped/initial-value-ones counts).
module phase_measure_dprintf_summary #(
   parameter logic [15:0] ADDRESS      = 16'd80,
   parameter int unsigned LOG2_SAMPLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        measure_response__valid,
   input  logic        measure_response__abort,
   input  logic        measure_response__initial_value,
   input  logic [8:0]  measure_response__delay,
   input  logic [8:0]  measure_response__initial_delay,
   output logic        dprintf_req__valid,
   output logic [15:0] dprintf_req__address,
   output logic [63:0] dprintf_req__data_0,
   output logic [63:0] dprintf_req__data_1,
   output logic [63:0] dprintf_req__data_2,
   output logic [63:0] dprintf_req__data_3,
   input  logic        dprintf_ack
);

   localparam int unsigned NumSamples = 1 << LOG2_SAMPLES;
   localparam int unsigned CntW       = LOG2_SAMPLES + 1;
   localparam int unsigned SumW       = 9 + LOG2_SAMPLES;
   localparam logic [CntW-1:0] CntFull = CntW'(NumSamples);

   typedef enum logic {StAccum, StEmit} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q, cnt_n, ones_q, ones_n;
   logic [SumW-1:0]   sum_q, sum_n;
   logic [8:0]        min_q, min_n, max_q, max_n, mean_n;
   logic [7:0]        abort_q, dropped_q;
   logic              in_accum, sample, abort_ev, done;
   logic              unused_initial_delay;

   assign unused_initial_delay = ^measure_response__initial_delay;
   assign dprintf_req__address = ADDRESS;
   assign dprintf_req__data_2  = 64'h0;
   assign dprintf_req__data_3  = 64'h0;

   // Next-state values include the current sample so the final sample is
   // folded into the payload on the same edge that captures it.
   always_comb begin
      in_accum = (state_q == StAccum);
      sample   = measure_response__valid & ~measure_response__abort & in_accum;
      abort_ev = measure_response__valid & measure_response__abort & in_accum;
      cnt_n    = cnt_q + CntW'(sample);
      sum_n    = sum_q + (sample ? SumW'(measure_response__delay) : '0);
      min_n    = (sample && measure_response__delay < min_q) ? measure_response__delay : min_q;
      max_n    = (sample && measure_response__delay > max_q) ? measure_response__delay : max_q;
      ones_n   = ones_q + CntW'(sample & measure_response__initial_value);
      done     = sample && (cnt_n == CntFull);
      mean_n   = sum_n[SumW-1:LOG2_SAMPLES];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q             <= StAccum;
         dprintf_req__valid  <= 1'b0;
         dprintf_req__data_0 <= 64'h0;
         dprintf_req__data_1 <= 64'h0;
         cnt_q               <= '0;
         sum_q               <= '0;
         ones_q              <= '0;
         min_q               <= 9'h1ff;
         max_q               <= 9'h0;
         abort_q             <= 8'h0;
         dropped_q           <= 8'h0;
      end else begin
         case (state_q)
            StAccum: begin
               if (done) begin
                  dprintf_req__data_0 <= {8'h87, 7'h0, min_n, 7'h0, max_n, 7'h0, mean_n, 8'hff};
                  dprintf_req__data_1 <= {8'h83, abort_q, dropped_q, 8'(ones_n), 8'hff, 24'h0};
                  dprintf_req__valid  <= 1'b1;
                  state_q             <= StEmit;
                  cnt_q               <= '0;
                  sum_q               <= '0;
                  ones_q              <= '0;
                  min_q               <= 9'h1ff;
                  max_q               <= 9'h0;
                  abort_q             <= 8'h0;
                  dropped_q           <= 8'h0;
               end else begin
                  cnt_q  <= cnt_n;
                  sum_q  <= sum_n;
                  ones_q <= ones_n;
                  min_q  <= min_n;
                  max_q  <= max_n;
                  if (abort_ev && abort_q != 8'hff) abort_q <= abort_q + 8'd1;
               end
            end
            StEmit: begin
               // Anything arriving while a request is outstanding is only counted.
               if (measure_response__valid && dropped_q != 8'hff) dropped_q <= dropped_q + 8'd1;
               if (dprintf_ack) begin
                  dprintf_req__valid <= 1'b0;
                  state_q            <= StAccum;
               end
            end
            default: state_q <= StAccum;
         endcase
      end
   end

endmodule
